m_set_bit_enum: RTL

M_SET_BIT_ENUM -- requirements
Module: m_set_bit_enum

---
 rtl/m_count_ones.sv | 18 +
 rtl/m_set_bit_enum.sv | 92 +++++++++
 2 files changed

// File: rtl/m_count_ones.sv
// Combinational popcount of an INPUT_SIZE-bit vector.
module m_count_ones #(
  parameter int INPUT_SIZE = 42
) (
  input  logic [INPUT_SIZE-1:0]         i_data,
  output logic [$clog2(INPUT_SIZE+1)-1:0] o_count
);

  localparam int CNT_W = $clog2(INPUT_SIZE + 1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      o_count = o_count + CNT_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/m_set_bit_enum.sv
// Accepts a mask and streams out the positions of its set bits, lowest first,
// one beat per handshake, with popcount and a completion pulse.
module m_set_bit_enum #(
  parameter int INPUT_SIZE = 42
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [INPUT_SIZE-1:0]           i_data,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [$clog2(INPUT_SIZE)-1:0]   o_index,
  output logic                            o_last,
  output logic [$clog2(INPUT_SIZE+1)-1:0] o_count,
  output logic                            o_done
);

  localparam int IDX_W = $clog2(INPUT_SIZE);
  localparam int CNT_W = $clog2(INPUT_SIZE + 1);
  localparam logic [INPUT_SIZE-1:0] ONE = INPUT_SIZE'(1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [INPUT_SIZE-1:0] mask;
  logic [INPUT_SIZE-1:0] mask_clr;
  logic [CNT_W-1:0]      popcnt;
  logic                  accept;
  logic                  beat;

  m_count_ones #(
    .INPUT_SIZE(INPUT_SIZE)
  ) u_count_ones (
    .i_data (i_data),
    .o_count(popcnt)
  );

  assign o_ready = (state == IDLE);
  assign o_valid = (state == EMIT);
  assign accept  = i_valid && o_ready;
  assign beat    = o_valid && i_ready;

  // Clearing the lowest set bit: x & (x-1).
  assign mask_clr = mask & (mask - ONE);
  assign o_last   = (mask != '0) && (mask_clr == '0);

  always_comb begin
    o_index = '0;
    for (int i = INPUT_SIZE - 1; i >= 0; i--) begin
      if (mask[i]) o_index = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && (i_data != '0)) state_nxt = EMIT;
      EMIT: if (beat && o_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mask    <= '0;
      o_count <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (accept) begin
        mask    <= i_data;
        o_count <= popcnt;
        // An empty mask completes immediately without entering EMIT.
        if (i_data == '0) o_done <= 1'b1;
      end else if (beat) begin
        mask <= mask_clr;
        if (o_last) o_done <= 1'b1;
      end
    end
  end

endmodule
